// File: rtl/fetch_stage.sv
// Fetch stage: PC register, fetch/decode pipeline register, BOOT/RUN/HALT control
// and saturating stall/flush performance counters. All outputs come straight from flops.
module fetch_stage #(
    parameter int unsigned        PCWIDTH    = 32,
    parameter int unsigned        INSTRWIDTH = 32,
    parameter int unsigned        PCSTEP     = 4,
    parameter logic [PCWIDTH-1:0] RESETPC    = '0,
    parameter logic [3:0]         HALTOPCODE = 4'hF,
    parameter int unsigned        COUNTWIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stallF,
    input  logic                  stallD,
    input  logic                  flushD,
    input  logic                  takeBranchE,
    input  logic [PCWIDTH-1:0]    branchTargetE,
    input  logic [INSTRWIDTH-1:0] instrF,
    output logic [PCWIDTH-1:0]    pcF,
    output logic [INSTRWIDTH-1:0] instrD,
    output logic [PCWIDTH-1:0]    pcPlusStepD,
    output logic                  validD,
    output logic                  halted,
    output logic [COUNTWIDTH-1:0] stallCount,
    output logic [COUNTWIDTH-1:0] flushCount
);

    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

    state_e                  state_q, state_d;
    logic [PCWIDTH-1:0]      pc_q, pc_d;
    logic [INSTRWIDTH-1:0]   instr_q, instr_d;
    logic [PCWIDTH-1:0]      pcp_q, pcp_d;
    logic                    valid_q, valid_d;
    logic [COUNTWIDTH-1:0]   stall_cnt_q, stall_cnt_d;
    logic [COUNTWIDTH-1:0]   flush_cnt_q, flush_cnt_d;

    logic                    halt_d;
    logic                    hold_fetch;
    logic [PCWIDTH-1:0]      pc_step;

    assign pc_step = pc_q + PCWIDTH'(PCSTEP);

    // A halt in D is only honoured if it will actually leave D this cycle.
    assign halt_d = (state_q == StRun) && valid_q &&
                    (instr_q[INSTRWIDTH-1 -: 4] == HALTOPCODE) && !flushD && !stallD;

    assign hold_fetch = (state_q != StRun) || halt_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:  state_d = StRun;
            StRun:   if (halt_d) state_d = StHalt;
            StHalt:  state_d = StHalt;
            default: state_d = StBoot;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (takeBranchE && (state_q != StBoot)) begin
            pc_d = branchTargetE;
        end else if (!hold_fetch && !stallF) begin
            pc_d = pc_step;
        end
    end

    always_comb begin
        instr_d = instr_q;
        pcp_d   = pcp_q;
        valid_d = valid_q;
        if (flushD || (!stallD && hold_fetch)) begin
            instr_d = '0;
            pcp_d   = '0;
            valid_d = 1'b0;
        end else if (!stallD) begin
            instr_d = instrF;
            pcp_d   = pc_step;
            valid_d = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stallF && !takeBranchE && (state_q == StRun) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + COUNTWIDTH'(1);
        end
        if (flushD && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + COUNTWIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StBoot;
            pc_q        <= RESETPC;
            instr_q     <= '0;
            pcp_q       <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pcp_q       <= pcp_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pcF         = pc_q;
    assign instrD      = instr_q;
    assign pcPlusStepD = pcp_q;
    assign validD      = valid_q;
    assign halted      = (state_q == StHalt);
    assign stallCount  = stall_cnt_q;
    assign flushCount  = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: decode-stage captures go through a scoreboard queue,
// PC/control/counter state is checked directly after each edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stallF, stallD, flushD, takeBranchE;
    logic [31:0] branchTargetE;
    logic [31:0] instrF;
    logic [31:0] pcF, instrD, pcPlusStepD;
    logic        validD, halted;
    logic [15:0] stallCount, flushCount;

    logic        override_en;

    // Narrow instance for PC wrap and counter saturation.
    logic        stallF8;
    logic [7:0]  branchTarget8;
    logic [31:0] instrF8;
    logic [7:0]  pcF8, pcPlus8;
    logic [31:0] instrD8;
    logic        valid8, halted8;
    logic [3:0]  stallCount8, flushCount8;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcp;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Instruction memory image: word at pc is 0x11 + (pc << 8).
    always_comb instrF = override_en ? 32'hF000_0000 : (32'h11 + (pcF << 8));

    fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stallF       (stallF),
        .stallD       (stallD),
        .flushD       (flushD),
        .takeBranchE  (takeBranchE),
        .branchTargetE(branchTargetE),
        .instrF       (instrF),
        .pcF          (pcF),
        .instrD       (instrD),
        .pcPlusStepD  (pcPlusStepD),
        .validD       (validD),
        .halted       (halted),
        .stallCount   (stallCount),
        .flushCount   (flushCount)
    );

    fetch_stage #(
        .PCWIDTH   (8),
        .RESETPC   (8'hFC),
        .COUNTWIDTH(4)
    ) dut8 (
        .clk          (clk),
        .reset        (reset),
        .stallF       (stallF8),
        .stallD       (1'b0),
        .flushD       (1'b0),
        .takeBranchE  (1'b0),
        .branchTargetE(branchTarget8),
        .instrF       (instrF8),
        .pcF          (pcF8),
        .instrD       (instrD8),
        .pcPlusStepD  (pcPlus8),
        .validD       (valid8),
        .halted       (halted8),
        .stallCount   (stallCount8),
        .flushCount   (flushCount8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step(input logic sf, input logic sd, input logic fd, input logic br,
                        input logic [31:0] tgt);
        stallF        = sf;
        stallD        = sd;
        flushD        = fd;
        takeBranchE   = br;
        branchTargetE = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pcp);
        exp_t x;
        x.instr = instr;
        x.pcp   = pcp;
        sb_q.push_back(x);
    endtask

    // Monitor: every valid decode-stage presentation must match the oldest expectation.
    always @(negedge clk) begin
        if (validD === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected actual=%h/%h required=no_valid", instrD, pcPlusStepD);
            end else begin
                e = sb_q.pop_front();
                if (instrD !== e.instr || pcPlusStepD !== e.pcp) begin
                    errors++;
                    $display("FAIL sb_capture actual=%h/%h required=%h/%h",
                             instrD, pcPlusStepD, e.instr, e.pcp);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        override_en = 1'b0;
        stallF = 1'b0; stallD = 1'b0; flushD = 1'b0; takeBranchE = 1'b0;
        branchTargetE = '0;
        stallF8 = 1'b0; branchTarget8 = '0; instrF8 = '0;

        @(posedge clk);
        #1;
        chk("rst_pc", pcF, 32'h0);
        chk("rst_valid", {31'b0, validD}, 32'h0);
        chk("rst_instr", instrD, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        chk("rst_counts", {stallCount, flushCount}, 32'h0);
        #5;
        reset = 1'b1;

        // Edge 1: BOOT, nothing captured yet.
        step(0, 0, 0, 0, 0);
        chk("boot_pc", pcF, 32'h0);
        chk("boot_valid", {31'b0, validD}, 32'h0);
        // Edge 2: first capture.
        step(0, 0, 0, 0, 0);
        chk("run_pc4", pcF, 32'h4);
        push(32'h11, 32'h4);
        step(0, 0, 0, 0, 0);
        chk("run_pc8", pcF, 32'h8);
        push(32'h411, 32'h8);

        // Two-cycle stall of F and D.
        step(1, 1, 0, 0, 0);
        push(32'h411, 32'h8);
        chk("stall1_cnt", {16'b0, stallCount}, 32'd1);
        step(1, 1, 0, 0, 0);
        push(32'h411, 32'h8);
        chk("stall2_pc", pcF, 32'h8);
        chk("stall2_cnt", {16'b0, stallCount}, 32'd2);
        step(0, 0, 0, 0, 0);
        chk("resume_pc", pcF, 32'hC);
        push(32'h811, 32'hC);
        step(0, 0, 0, 0, 0);
        push(32'hC11, 32'h10);

        // Branch beats a simultaneous fetch stall; flush bubbles D.
        step(1, 0, 1, 1, 32'h40);
        chk("br_pc", pcF, 32'h40);
        chk("br_valid", {31'b0, validD}, 32'h0);
        chk("br_flushcnt", {16'b0, flushCount}, 32'd1);
        chk("br_stallcnt", {16'b0, stallCount}, 32'd2);
        step(0, 0, 0, 0, 0);
        chk("br_next_pc", pcF, 32'h44);
        push(32'h4011, 32'h44);

        // Halt opcode in D discarded by flush.
        override_en = 1'b1;
        step(0, 0, 0, 0, 0);
        override_en = 1'b0;
        push(32'hF000_0000, 32'h48);
        step(0, 0, 1, 0, 0);
        chk("hflush_halted", {31'b0, halted}, 32'h0);
        chk("hflush_pc", pcF, 32'h4C);
        chk("hflush_flushcnt", {16'b0, flushCount}, 32'd2);
        step(0, 0, 0, 0, 0);
        chk("hflush_run_pc", pcF, 32'h50);
        push(32'h4C11, 32'h50);

        // Real halt.
        override_en = 1'b1;
        step(0, 0, 0, 0, 0);
        override_en = 1'b0;
        push(32'hF000_0000, 32'h54);
        step(0, 0, 0, 0, 0);
        chk("halt_halted", {31'b0, halted}, 32'h1);
        chk("halt_pc", pcF, 32'h54);
        chk("halt_valid", {31'b0, validD}, 32'h0);
        step(1, 0, 0, 0, 0);
        chk("halt_hold_pc", pcF, 32'h54);
        chk("halt_stallcnt", {16'b0, stallCount}, 32'd2);
        chk("halt_still", {31'b0, halted}, 32'h1);

        // Asynchronous reset between edges while halted.
        #2;
        reset = 1'b0;
        #1;
        chk("areset_pc", pcF, 32'h0);
        chk("areset_halted", {31'b0, halted}, 32'h0);
        chk("areset_valid", {31'b0, validD}, 32'h0);
        chk("areset_counts", {stallCount, flushCount}, 32'h0);
        #3;
        reset = 1'b1;

        // BOOT ignores a branch but still counts a flush.
        step(0, 0, 1, 1, 32'h80);
        chk("reboot_pc", pcF, 32'h0);
        chk("reboot_flushcnt", {16'b0, flushCount}, 32'd1);
        chk("reboot_stallcnt", {16'b0, stallCount}, 32'd0);
        chk("w8_boot_pc", {24'b0, pcF8}, 32'hFC);
        step(0, 0, 0, 0, 0);
        chk("reboot_run_pc", pcF, 32'h4);
        push(32'h11, 32'h4);
        chk("w8_wrap_pc", {24'b0, pcF8}, 32'h00);

        // Narrow instance: stall counter saturates; main DUT flushed meanwhile.
        stallF8 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step(0, 0, 1, 0, 0);
            if (i == 13) chk("sat_e", {28'b0, stallCount8}, 32'hE);
            if (i == 14) chk("sat_f", {28'b0, stallCount8}, 32'hF);
        end
        stallF8 = 1'b0;
        chk("sat_hold", {28'b0, stallCount8}, 32'hF);
        chk("w8_stall_pc", {24'b0, pcF8}, 32'h00);

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
